// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path widths and output-buffer occupancy encoding
package cpu_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_count_t;

endpackage

// File: rtl/imem_store.sv
// rtl/imem_store.sv - single-clock instruction store, read-first synchronous read, one write port
module imem_store #(
  parameter int    ADDR_W    = cpu_pkg::ADDR_W,
  parameter int    DATA_W    = cpu_pkg::DATA_W,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Read and write share one edge; the read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch responder: store read, 2-entry output buffer, PC stall and flush
module imem_responder #(
  parameter int    ADDR_W    = cpu_pkg::ADDR_W,
  parameter int    DATA_W    = cpu_pkg::DATA_W,
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instr_address,
  input  logic              flush,
  output logic              pc_stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  import cpu_pkg::*;

  buf_count_t        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] tail_instr_q, tail_instr_d;
  logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        occupancy;
  logic              push, pop, accept;

  imem_store #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_store (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(instr_address),
    .rd_data(rd_data)
  );

  // Stall counts the in-flight read as a reserved slot so the buffer never overflows.
  assign occupancy = 2'(count_q) + {1'b0, inflight_q};
  assign out_valid = (count_q != EMPTY) && !flush;
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;
  assign pc_stall  = (occupancy == 2'd2) && !pop;
  assign accept    = !pc_stall && !flush;

  always_comb begin
    count_d      = count_q;
    inflight_d   = accept;
    rd_addr_d    = accept ? instr_address : rd_addr_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    tail_instr_d = tail_instr_q;
    tail_addr_d  = tail_addr_q;
    if (flush) begin
      count_d = EMPTY;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == EMPTY) begin
            out_instr_d = rd_data;
            out_addr_d  = rd_addr_q;
            count_d     = ONE;
          end else begin
            tail_instr_d = rd_data;
            tail_addr_d  = rd_addr_q;
            count_d      = TWO;
          end
        end
        2'b01: begin
          if (count_q == TWO) begin
            out_instr_d = tail_instr_q;
            out_addr_d  = tail_addr_q;
            count_d     = ONE;
          end else begin
            count_d = EMPTY;
          end
        end
        2'b11: begin
          if (count_q == TWO) begin
            out_instr_d  = tail_instr_q;
            out_addr_d   = tail_addr_q;
            tail_instr_d = rd_data;
            tail_addr_d  = rd_addr_q;
          end else begin
            out_instr_d = rd_data;
            out_addr_d  = rd_addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= EMPTY;
      inflight_q   <= 1'b0;
      rd_addr_q    <= '0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      tail_instr_q <= '0;
      tail_addr_q  <= '0;
    end else begin
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      rd_addr_q    <= rd_addr_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      tail_instr_q <= tail_instr_d;
      tail_addr_q  <= tail_addr_d;
    end
  end

  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed bench for imem_responder acting as PC and decode
module tb_imem_responder;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          out_ready;
  logic          wr_en;
  logic [AW-1:0] instr_address;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          pc_stall;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_addr;

  logic [AW-1:0] pc;
  logic          s_stall, s_valid;
  logic [DW-1:0] s_instr;
  logic [AW-1:0] s_addr;
  logic [AW-1:0] exp_a;
  logic [DW-1:0] exp_i;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .DEPTH    (1024),
    .INIT_FILE("")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_address(instr_address),
    .flush        (flush),
    .pc_stall     (pc_stall),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_addr     (out_addr),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data)
  );

  // Entered at posedge+1: drive one cycle, sample mid-cycle, advance the PC if accepted.
  task automatic tick(input logic rdy, input logic fl);
    out_ready     = rdy;
    flush         = fl;
    instr_address = pc;
    #2;
    s_stall = pc_stall;
    s_valid = out_valid;
    s_instr = out_instr;
    s_addr  = out_addr;
    @(posedge clk);
    #1;
    if (!s_stall && !fl) pc = pc + 10'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_en = 1'b0;
    instr_address = '0; wr_addr = '0; wr_data = '0; pc = '0;
    #1;
    checks++;
    if ({out_valid, pc_stall, out_addr, out_instr} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b s=%b a=%h i=%h want all zero", out_valid, pc_stall, out_addr, out_instr);
    end
    for (int k = 0; k < 1024; k++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = DW'(k + 16'h100);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (k < 2) begin
        if ({s_valid, s_stall} !== 2'b00) begin
          errors++;
          $display("FAIL stream_idle k=%0d got v=%b s=%b want v=0 s=0", k, s_valid, s_stall);
        end
      end else begin
        exp_a = AW'(k - 2);
        exp_i = DW'(k - 2 + 16'h100);
        if ({s_valid, s_stall, s_addr, s_instr} !== {1'b1, 1'b0, exp_a, exp_i}) begin
          errors++;
          $display("FAIL stream k=%0d got v=%b s=%b a=%h i=%h want v=1 s=0 a=%h i=%h",
                   k, s_valid, s_stall, s_addr, s_instr, exp_a, exp_i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({s_valid, s_stall, s_addr, s_instr} !== {1'b1, 1'b1, 10'h005, 16'h0105}) begin
        errors++;
        $display("FAIL bp_hold k=%0d got v=%b s=%b a=%h i=%h want v=1 s=1 a=005 i=0105",
                 k, s_valid, s_stall, s_addr, s_instr);
      end
    end
    checks++;
    if (dut.count_q !== 2'd2) begin
      errors++;
      $display("FAIL bp_count got %0d want 2", dut.count_q);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0);
      exp_a = AW'(5 + k);
      exp_i = DW'(5 + k + 16'h100);
      checks++;
      if ({s_valid, s_stall, s_addr, s_instr} !== {1'b1, 1'b0, exp_a, exp_i}) begin
        errors++;
        $display("FAIL bp_resume k=%0d got v=%b s=%b a=%h i=%h want v=1 s=0 a=%h i=%h",
                 k, s_valid, s_stall, s_addr, s_instr, exp_a, exp_i);
      end
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle got v=%b want v=0", s_valid);
    end
    pc = 10'h3F0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if ({s_valid, s_stall} !== 2'b00) begin
        errors++;
        $display("FAIL flush_gap k=%0d got v=%b s=%b a=%h want v=0 s=0", k, s_valid, s_stall, s_addr);
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 18; k++) begin
      tick(1'b1, 1'b0);
      exp_a = AW'(10'h3F0 + k);
      exp_i = {6'b0, exp_a} + 16'h100;
      checks++;
      if ({s_valid, s_stall, s_addr, s_instr} !== {1'b1, 1'b0, exp_a, exp_i}) begin
        errors++;
        $display("FAIL wrap k=%0d got v=%b s=%b a=%h i=%h want v=1 s=0 a=%h i=%h",
                 k, s_valid, s_stall, s_addr, s_instr, exp_a, exp_i);
      end
    end
  endtask

  task automatic test_write_collision();
    tick(1'b1, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL wc_flush got v=%b want v=0", s_valid);
    end
    pc = 10'd20;
    wr_en = 1'b1; wr_addr = 10'd20; wr_data = 16'hBEEF;
    tick(1'b1, 1'b0);
    wr_en = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if ({s_valid, s_addr, s_instr} !== {1'b1, 10'd20, 16'h0114}) begin
      errors++;
      $display("FAIL wc_old got v=%b a=%h i=%h want v=1 a=014 i=0114", s_valid, s_addr, s_instr);
    end
    tick(1'b1, 1'b1);
    pc = 10'd20;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checks++;
    if ({s_valid, s_addr, s_instr} !== {1'b1, 10'd20, 16'hBEEF}) begin
      errors++;
      $display("FAIL wc_new got v=%b a=%h i=%h want v=1 a=014 i=beef", s_valid, s_addr, s_instr);
    end
  endtask

  task automatic test_reset_midop();
    tick(1'b1, 1'b1);
    pc = 10'h040;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if ({s_valid, s_stall, s_addr, s_instr} !== {1'b1, 1'b1, 10'h040, 16'h0140}) begin
      errors++;
      $display("FAIL rm_fill got v=%b s=%b a=%h i=%h want v=1 s=1 a=040 i=0140",
               s_valid, s_stall, s_addr, s_instr);
    end
    checks++;
    if (dut.count_q !== 2'd2) begin
      errors++;
      $display("FAIL rm_count got %0d want 2", dut.count_q);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, pc_stall, out_addr, out_instr} !== 28'd0) begin
      errors++;
      $display("FAIL rm_async got v=%b s=%b a=%h i=%h want all zero", out_valid, pc_stall, out_addr, out_instr);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    pc = '0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (k < 2) begin
        if (s_valid !== 1'b0) begin
          errors++;
          $display("FAIL rm_restart_idle k=%0d got v=%b want v=0", k, s_valid);
        end
      end else begin
        exp_a = AW'(k - 2);
        exp_i = DW'(k - 2 + 16'h100);
        if ({s_valid, s_addr, s_instr} !== {1'b1, exp_a, exp_i}) begin
          errors++;
          $display("FAIL rm_restart k=%0d got v=%b a=%h i=%h want v=1 a=%h i=%h",
                   k, s_valid, s_addr, s_instr, exp_a, exp_i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap();
    test_write_collision();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
